scan_addr_ctrl: RTL

//  Sequencer for the 14-bit pixel address counter (clear/keep/count interface). Runs one raster scan
//  of PIX_NUM addresses per start pulse: holds counter at 0 when idle, increments it once per issued

---
 rtl/scan_addr_ctrl_if.sv | 27 ++
 rtl/scan_addr_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/scan_addr_ctrl_if.sv
// Handshake bundle between the scan sequencer, the pixel address counter and the image memory.
// slave = sequencer side, master = surrounding logic (FSM, counter, memory).
interface scan_addr_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic              abort;
  logic              stall;
  logic [ADDR_W-1:0] count;
  logic              clear;
  logic              keep;
  logic              rd_en;
  logic              data_vld;
  logic              busy;
  logic              done;
  logic              row_end;

  modport slave (
    input  start, abort, stall, count,
    output clear, keep, rd_en, data_vld, busy, done, row_end
  );

  modport master (
    output start, abort, stall, count,
    input  clear, keep, rd_en, data_vld, busy, done, row_end
  );
endinterface

// File: rtl/scan_addr_ctrl.sv
// Raster-scan sequencer driving a clear/keep/count address counter and tracking memory read latency.
// Optional row-end flag is compiled in when ROW_END_EN is defined.
module scan_addr_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int PIX_NUM = 16384,
  parameter int RD_LAT  = 1,
  parameter int IMG_W   = 128
) (
  input  logic             clk,
  input  logic             rst,
  scan_addr_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PIX_NUM - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

  logic clear;
  logic keep;
  logic rd_en;
  logic done;
  logic flush;
  logic data_vld;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    clear       = 1'b0;
    keep        = 1'b0;
    rd_en       = 1'b0;
    done        = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clear       = 1'b1;
        drain_cnt_d = 2'd0;
        if (bus.start && !bus.abort) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort) begin
          keep    = 1'b1;
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.stall) begin
          keep = 1'b1;
        end else begin
          rd_en = 1'b1;
          // Last address: hold the counter so it never wraps past the image.
          if (bus.count == LAST_ADDR) begin
            keep        = 1'b1;
            drain_cnt_d = 2'd0;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        keep = 1'b1;
        if (bus.abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        keep    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads already issued keep moving through the pipe even while stalled.
  always_comb begin
    vld_pipe_d = '0;
    if (!flush) begin
      vld_pipe_d[0] = rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 2'd0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  assign data_vld     = vld_pipe_q[RD_LAT-1];
  assign bus.clear    = clear;
  assign bus.keep     = keep;
  assign bus.rd_en    = rd_en;
  assign bus.data_vld = data_vld;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done;

`ifdef ROW_END_EN
  localparam int               COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    col_d = col_q;
    if (state_q == ST_IDLE || flush) begin
      col_d = '0;
    end else if (data_vld) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) col_q <= '0;
    else      col_q <= col_d;
  end

  assign bus.row_end = data_vld && (col_q == COL_LAST);
`else
  // Row tracking absent: IMG_W >= 1 makes this term constant 0.
  assign bus.row_end = data_vld && (IMG_W < 1);
`endif

endmodule
